// File: rtl/operand_pkg.sv
// Shared constants and types for the operand fetch stage.
//   DATA_W / NREGS / ADDR_W : datapath width, register count, index width
//   shift_t                 : 1-bit shifter operation applied to Rm
//   fetch_state_t           : operand fetch FSM states
package operand_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        READ_A = 2'b01,
        READ_B = 2'b10,
        VALID  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/shifter.sv
// Combinational 1-bit shifter on the B operand path.
//   in_i    : operand to shift
//   shift_i : SH_NONE pass, SH_LSL/SH_LSR zero fill, SH_ASR sign fill
//   out_o   : shifted operand
module shifter
    import operand_pkg::*;
(
    input  logic [DATA_W-1:0] in_i,
    input  shift_t            shift_i,
    output logic [DATA_W-1:0] out_o
);

    always_comb begin
        out_o = in_i;
        unique case (shift_i)
            SH_NONE: out_o = in_i;
            SH_LSL:  out_o = {in_i[DATA_W-2:0], 1'b0};
            SH_LSR:  out_o = {1'b0, in_i[DATA_W-1:1]};
            SH_ASR:  out_o = {in_i[DATA_W-1], in_i[DATA_W-1:1]};
            default: out_o = in_i;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage in front of the ALU.
// Holds the 8x16 register file (written from writeback), and on an accepted
// request reads Rn (READ_A) then Rm (READ_B), shifts Rm, applies the A/B
// source muxes and presents the pair in VALID.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1 (req_ready is 1 only in IDLE). An operand pair
// transfers on a rising edge where op_valid and op_ready are both 1
// (op_valid is 1 only in VALID). Ain/Bin/alu_op_out hold stable from the
// moment op_valid rises until that transfer, and keep their last values
// afterwards; consumers must qualify them with op_valid.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data     : register file write port (any state)
//   req_valid, req_ready        : request handshake
//   rn, rm, shift, asel, bsel,
//   sximm5, alu_op_in           : request fields, captured on accept
//   op_valid, op_ready          : operand handshake
//   Ain, Bin, alu_op_out        : operand pair presented to the ALU
//   state_o                     : current FSM state (debug)
module operand_fetch
    import operand_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rn,
    input  logic [ADDR_W-1:0] rm,
    input  logic [1:0]        shift,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] sximm5,
    input  logic [1:0]        alu_op_in,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    output logic [1:0]        alu_op_out,
    output fetch_state_t      state_o
);

    fetch_state_t      state_q;
    logic [DATA_W-1:0] regs_q [NREGS];

    // request registers
    logic [ADDR_W-1:0] rn_q;
    logic [ADDR_W-1:0] rm_q;
    shift_t            shift_q;
    logic              asel_q;
    logic              bsel_q;
    logic [DATA_W-1:0] sximm5_q;
    logic [1:0]        op_q;

    // latched A operand and presented outputs
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] ain_q;
    logic [DATA_W-1:0] bin_q;
    logic [1:0]        alu_op_q;

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] b_shifted;

    // Register file: a write lands on any edge regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Write-through: a write to the register being read in the same cycle
    // is seen by the read, so the operand never misses a just-retired value.
    assign rd_a = (wr_en && (wr_addr == rn_q)) ? wr_data : regs_q[rn_q];
    assign rd_b = (wr_en && (wr_addr == rm_q)) ? wr_data : regs_q[rm_q];

    shifter u_shifter (
        .in_i    (rd_b),
        .shift_i (shift_q),
        .out_o   (b_shifted)
    );

    // FSM plus request/operand capture. The B mux result is registered at the
    // READ_B edge, so the presented pair only changes on entry to VALID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rn_q     <= '0;
            rm_q     <= '0;
            shift_q  <= SH_NONE;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            sximm5_q <= '0;
            op_q     <= '0;
            a_q      <= '0;
            ain_q    <= '0;
            bin_q    <= '0;
            alu_op_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rn_q     <= rn;
                        rm_q     <= rm;
                        shift_q  <= shift_t'(shift);
                        asel_q   <= asel;
                        bsel_q   <= bsel;
                        sximm5_q <= sximm5;
                        op_q     <= alu_op_in;
                        state_q  <= READ_A;
                    end
                end
                READ_A: begin
                    a_q     <= rd_a;
                    state_q <= READ_B;
                end
                READ_B: begin
                    ain_q    <= asel_q ? '0 : a_q;
                    bin_q    <= bsel_q ? sximm5_q : b_shifted;
                    alu_op_q <= op_q;
                    state_q  <= VALID;
                end
                VALID: begin
                    if (op_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign op_valid   = (state_q == VALID);
    assign Ain        = ain_q;
    assign Bin        = bin_q;
    assign alu_op_out = alu_op_q;
    assign state_o    = state_q;

endmodule
